fft_bitrev_buffer: RTL

//  Receive-path stage between CP removal and the FFT core. Collects NFFT
//  CP-free samples per symbol into a ping-pong buffer (2 banks x NFFT words),

---
 rtl/fft_bitrev_buffer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/fft_bitrev_buffer.sv
// Ping-pong sample buffer between CP removal and the DIT FFT core.
// Each complete symbol is replayed in bit-reversed index order.
//
// state  | meaning
// IDLE   | no full bank waiting, CYC_O low
// LOAD   | one-cycle read of word bitrev(0) from the read bank
// SEND   | STB_O held until ACK_I; next word fetched on each accept
module fft_bitrev_buffer #(
    parameter int NFFT  = 256,
    parameter int LOG2N = 8,
    parameter int DW    = 32
) (
    input  logic          CLK_I,
    input  logic          RST_I,
    input  logic [DW-1:0] DAT_I,
    input  logic          CYC_I,
    input  logic          STB_I,
    input  logic          WE_I,
    output logic          ACK_O,
    output logic [DW-1:0] DAT_O,
    output logic          CYC_O,
    output logic          STB_O,
    output logic          WE_O,
    input  logic          ACK_I
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND} state_t;

    logic [DW-1:0]    mem_q [2*NFFT];
    logic [LOG2N-1:0] wr_cnt_q;
    logic [LOG2N-1:0] rd_cnt_q;
    logic             wbank_q;
    logic             rbank_q;
    logic [1:0]       full_q;
    logic [1:0]       full_d;
    state_t           state_q;
    logic [DW-1:0]    dat_q;
    logic             cyc_q;
    logic             stb_q;

    logic             accept;
    logic             wr_last;
    logic             rd_fire;
    logic             rd_last;
    logic [LOG2N-1:0] rd_idx;
    logic [LOG2N:0]   rd_addr;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] k);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = k[LOG2N-1-i];
        end
        return r;
    endfunction

    // Gated by reset so no sample is acknowledged while the block is held in reset.
    assign accept  = RST_I & CYC_I & STB_I & WE_I & ~full_q[wbank_q];
    assign wr_last = accept & (wr_cnt_q == LOG2N'(NFFT-1));
    assign rd_fire = (state_q == S_SEND) & stb_q & ACK_I;
    assign rd_last = rd_fire & (rd_cnt_q == LOG2N'(NFFT-1));

    assign rd_idx  = (state_q == S_LOAD) ? '0 : rd_cnt_q + 1'b1;
    assign rd_addr = {rbank_q, bitrev(rd_idx)};

    assign ACK_O = accept;
    assign DAT_O = dat_q;
    assign CYC_O = cyc_q;
    assign STB_O = stb_q;
    assign WE_O  = stb_q;

    always_ff @(posedge CLK_I) begin
        if (accept) begin
            mem_q[{wbank_q, wr_cnt_q}] <= DAT_I;
        end
    end

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            wr_cnt_q <= '0;
            wbank_q  <= 1'b0;
        end else if (accept) begin
            if (wr_last) begin
                wr_cnt_q <= '0;
                wbank_q  <= ~wbank_q;
            end else begin
                wr_cnt_q <= wr_cnt_q + 1'b1;
            end
        end else if (!CYC_I) begin
            wr_cnt_q <= '0;
        end
    end

    // Writer and reader never target the same bank, so set and clear cannot collide.
    always_comb begin
        full_d = full_q;
        if (wr_last) full_d[wbank_q] = 1'b1;
        if (rd_last) full_d[rbank_q] = 1'b0;
    end

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            full_q <= 2'b00;
        end else begin
            full_q <= full_d;
        end
    end

    always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
            state_q  <= S_IDLE;
            rd_cnt_q <= '0;
            rbank_q  <= 1'b0;
            dat_q    <= '0;
            cyc_q    <= 1'b0;
            stb_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    stb_q <= 1'b0;
                    if (full_q[rbank_q]) begin
                        state_q <= S_LOAD;
                        cyc_q   <= 1'b1;
                    end
                end
                S_LOAD: begin
                    dat_q   <= mem_q[rd_addr];
                    stb_q   <= 1'b1;
                    state_q <= S_SEND;
                end
                S_SEND: begin
                    if (rd_last) begin
                        stb_q    <= 1'b0;
                        rd_cnt_q <= '0;
                        rbank_q  <= ~rbank_q;
                        // full_d covers a write finishing the other bank this same cycle
                        if (full_d[~rbank_q]) begin
                            state_q <= S_LOAD;
                        end else begin
                            state_q <= S_IDLE;
                            cyc_q   <= 1'b0;
                        end
                    end else if (rd_fire) begin
                        dat_q    <= mem_q[rd_addr];
                        rd_cnt_q <= rd_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cyc_q   <= 1'b0;
                    stb_q   <= 1'b0;
                end
            endcase
        end
    end

endmodule
